rib_rr_arbiter: RTL and testbench
=================================

# rib_rr_arbiter

Round-robin bus arbiter that shares the RIB slave fabric among the four RIB masters: core data port, core fetch port, JTAG, and UART download. It replaces fixed-priority selection with rotating fairness. It locks the grant across multi-cycle handshake slaves (e.g. I2C, req/ack) and bounds each lock with a timeout. It also produces the pipeline hold flag consumed by the core.

## Interface
Parameters:
- `NUM_M`, 4: number of masters; fixed at 4 in this SoC, and the index width is 2.
- `TIMEOUT_CYCLES`, 255: maximum cycles in WAIT before a forced release; legal range 1..255, 8-bit counter.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req_i`  in  4  per-master request; bit n = master n
- `slow_i`  in  1  the currently granted access targets a handshake slave (decoded by the fabric from the granted address)
- `ack_i`  in  1  handshake slave ack/data-ready
- `err_clr_i`  in  1  clears sticky `err_o`
- `grant_o`  out  4  one-hot grant, or all zeros
- `grant_idx_o`  out  2  binary index of the granted master; 0 when no grant
- `grant_vld_o`  out  1  `|grant_o`
- `hold_flag_o`  out  1  stall request to the core
- `timeout_o`  out  1  one-cycle pulse on a WAIT timeout
- `err_o`  out  1  sticky timeout flag

## Operation
- State: `ptr` (2 b, last granted index), `state` ∈ {ARB, WAIT}, `cnt` (8 b), `lock_idx` (2 b), `err_o`.
- **ARB:**
  - `grant_o` is combinational. It selects the first requester searching `ptr+1, ptr+2, ptr+3, ptr` (mod 4).
  - When no requester exists, grant = 0 and `ptr` is unchanged.
  - On the clock edge with a valid grant, `ptr` ← granted index.
  - If `slow_i`=1 with a valid grant and `ack_i`=0, go to WAIT. Set `lock_idx` ← granted index and `cnt` ← 0.
  - If `slow_i`=1 and `ack_i`=1 in the same cycle, the access completes and the arbiter stays in ARB.
- **WAIT:**
  - `grant_o` = one-hot(`lock_idx`), provided `req_i[lock_idx]`=1. Other requests are ignored and `ptr` is frozen.
  - `ack_i`=1 → ARB next cycle. The grant stays held during the ack cycle.
  - `req_i[lock_idx]`=0 (master abandons) → `grant_o`=0 in that cycle, ARB next cycle, no error.
  - `cnt` = `TIMEOUT_CYCLES`-1 with no ack → `timeout_o`=1 for that cycle, `err_o` ← 1, ARB next cycle. `ptr` stays `lock_idx`, so the next grant rotates away.
  - Otherwise `cnt` ← `cnt`+1.
- **Hold flag:** `hold_flag_o` = (state == WAIT) OR ((`req_i[0]` OR `req_i[1]`) AND `grant_idx_o` ∉ {0,1} AND `grant_vld_o`). It is combinational.
- **Error flag:** `err_clr_i` clears `err_o`. If a timeout and `err_clr_i` occur in the same cycle, the set wins.

## Timing
- **Reset values:**
  - `ptr`=3, so master 0 wins first.
  - state=ARB, `cnt`=0, `err_o`=0, `timeout_o`=0.
  - While `rst`=1: `grant_o`=0, `grant_vld_o`=0, `hold_flag_o`=0.
- **Latency:** zero-cycle grant from `req_i` in ARB. WAIT entry and exit each take effect at the next edge.
- **Fairness:** with N continuous requesters, each is granted exactly once every N grant cycles.
- **Timeout:** a locked access with no ack holds the grant for exactly `TIMEOUT_CYCLES` cycles. `timeout_o` fires in the last of those cycles.
- **Reset mid-WAIT:** everything returns to reset values at the next edge, with no timeout pulse.
- **Simultaneous events in WAIT:** `ack_i` together with the timeout-count cycle counts as an ack (no timeout). A dropped request together with `ack_i` counts as abandon; no error in either case.

## Test plan
- **Reset then all `req_i`=4'b1111, `slow_i`=0:** grant sequence 0,1,2,3,0,… one per cycle. `hold_flag_o`=1 exactly in the cycles granting 2 or 3.
- **`req_i`=4'b0010 constant, then 4'b1010 from cycle 5:** grant alternates 3,1,3,1. `ptr` is never lost across single-requester periods.
- **Grant master 3 with `slow_i`=1, `ack_i` at the 4th WAIT cycle, `req_i`=4'b1111:** `grant_idx_o`=3 for 5 cycles total. `hold_flag_o`=1 throughout WAIT. Next grant is 0.
- **`TIMEOUT_CYCLES`=8, slow access by master 2, no ack:** grant held 8 cycles. `timeout_o` pulses once on the 8th. `err_o`=1 until `err_clr_i`. Next grant is 3 (if requesting).
- **Master 2 in WAIT drops `req_i[2]` at cycle 3:** `grant_o`=0 that cycle, ARB next cycle, `err_o` stays 0.
- **`rst` asserted during WAIT at `cnt`=5:** next cycle state=ARB, `ptr`=3, `grant_o`=0, no `timeout_o`.

Source files
------------

// File: rtl/rib_rr_arbiter.sv
// Round-robin grant for the four RIB masters, locking the grant across handshake-slave accesses.
// Grant is zero-cycle from req_i in ARB; a lock ends on ack, abandon or timeout at the next edge.
module rib_rr_arbiter #(
  parameter int NUM_M          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req_i,
  input  logic             slow_i,
  input  logic             ack_i,
  input  logic             err_clr_i,
  output logic [NUM_M-1:0] grant_o,
  output logic [1:0]       grant_idx_o,
  output logic             grant_vld_o,
  output logic             hold_flag_o,
  output logic             timeout_o,
  output logic             err_o
);

  localparam int IDX_W = 2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {ST_ARB, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lock_q, lock_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             rr_vld;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic             timeout;

  // Search starts just after the last winner, so the last winner is checked last.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!rr_vld && req_i[cand]) begin
        rr_vld = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    timeout   = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (rr_vld) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx;
          ptr_d     = rr_idx;
          if (slow_i && !ack_i) begin
            state_d = ST_WAIT;
            lock_d  = rr_idx;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        // A dropped request outranks both ack and timeout: the master walked away.
        if (!req_i[lock_q]) begin
          state_d = ST_ARB;
        end else begin
          grant_vld = 1'b1;
          grant_idx = lock_q;
          if (ack_i) begin
            state_d = ST_ARB;
          end else if (cnt_q == CNT_LAST) begin
            timeout = 1'b1;
            state_d = ST_ARB;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (rst) begin
      grant_vld = 1'b0;
      grant_idx = '0;
      timeout   = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (timeout)   err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      ptr_q   <= 2'd3;
      lock_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign grant_o     = grant_vld ? (NUM_M'(1) << grant_idx) : '0;
  assign grant_idx_o = grant_idx;
  assign grant_vld_o = grant_vld;
  assign timeout_o   = timeout;
  assign err_o       = err_q;
  // Core stalls while locked, or while one of its ports waits behind a non-core grant.
  assign hold_flag_o = !rst && ((state_q == ST_WAIT) ||
                       ((req_i[0] || req_i[1]) && grant_vld && (grant_idx >= 2'd2)));

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Bench for rib_rr_arbiter: directed scenarios plus random traffic against a rotation/lock model.
module tb_rib_rr_arbiter;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       slow_i, ack_i, err_clr_i;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       grant_vld_o, hold_flag_o, timeout_o, err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rib_rr_arbiter #(.NUM_M(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .slow_i(slow_i), .ack_i(ack_i),
    .err_clr_i(err_clr_i), .grant_o(grant_o), .grant_idx_o(grant_idx_o),
    .grant_vld_o(grant_vld_o), .hold_flag_o(hold_flag_o),
    .timeout_o(timeout_o), .err_o(err_o)
  );

  // Model: who won last, whether some master owns the bus, and how long it has waited.
  int  m_last = 3;
  bit  m_busy = 0;
  int  m_owner = 0;
  int  m_age = 0;
  bit  m_err = 0;
  bit  e_vld, e_hold, e_tmo;
  int  e_idx;

  function automatic void model_eval();
    e_vld = 0; e_idx = 0; e_tmo = 0;
    if (!rst) begin
      if (m_busy) begin
        if (req_i[m_owner]) begin
          e_vld = 1; e_idx = m_owner;
          e_tmo = !ack_i && (m_age == TMO - 1);
        end
      end else begin
        for (int k = 1; k <= 4; k++)
          if (!e_vld && req_i[(m_last + k) % 4]) begin
            e_vld = 1; e_idx = (m_last + k) % 4;
          end
      end
    end
    e_hold = !rst && (m_busy || ((req_i[0] || req_i[1]) && e_vld && e_idx >= 2));
  endfunction

  function automatic void model_commit();
    if (rst) begin
      m_last = 3; m_busy = 0; m_age = 0; m_err = 0;
      return;
    end
    if (m_busy) begin
      if (!req_i[m_owner] || ack_i || e_tmo) m_busy = 0;
      else m_age++;
    end else if (e_vld) begin
      m_last = e_idx;
      if (slow_i && !ack_i) begin m_busy = 1; m_owner = e_idx; m_age = 0; end
    end
    if (e_tmo) m_err = 1;
    else if (err_clr_i) m_err = 0;
  endfunction

  task automatic drive(input logic r, input logic [3:0] q, input logic s, input logic a, input logic c);
    @(negedge clk);
    rst = r; req_i = q; slow_i = s; ack_i = a; err_clr_i = c;
    #1 model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
  endtask

  task automatic test_reset();
    drive(1, 4'b1111, 1, 0, 0);
    checks++; if (grant_o !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant_o); end
    checks++; if (grant_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", grant_vld_o); end
    checks++; if (hold_flag_o !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", hold_flag_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    tick();
    drive(0, 4'b0000, 0, 0, 0);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (grant_vld_o !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b expected 0", grant_vld_o); end
    tick();
  endtask

  task automatic test_rotation();
    for (int c = 0; c < 8; c++) begin
      logic [1:0] ei;
      ei = 2'(c % 4);
      drive(0, 4'b1111, 0, 0, 0);
      checks++; if (grant_idx_o !== ei) begin errors++; $display("FAIL rot_idx c=%0d: got %0d expected %0d", c, grant_idx_o, ei); end
      checks++; if (grant_o !== (4'b0001 << ei)) begin errors++; $display("FAIL rot_grant c=%0d: got %b", c, grant_o); end
      checks++; if (hold_flag_o !== (ei >= 2'd2)) begin errors++; $display("FAIL rot_hold c=%0d: got %b expected %b", c, hold_flag_o, ei >= 2'd2); end
      tick();
    end
  endtask

  task automatic test_sparse();
    for (int c = 0; c < 8; c++) begin
      logic [1:0] ei;
      ei = (c >= 5 && c % 2 == 1) ? 2'd3 : 2'd1;
      drive(0, (c < 5) ? 4'b0010 : 4'b1010, 0, 0, 0);
      checks++; if (grant_idx_o !== ei) begin errors++; $display("FAIL sparse_idx c=%0d: got %0d expected %0d", c, grant_idx_o, ei); end
      checks++; if (hold_flag_o !== (ei == 2'd3)) begin errors++; $display("FAIL sparse_hold c=%0d: got %b", c, hold_flag_o); end
      tick();
    end
  endtask

  task automatic test_slow_ack();
    drive(1, 4'b0000, 0, 0, 0); tick();
    for (int c = 0; c < 3; c++) begin drive(0, 4'b1111, 0, 0, 0); tick(); end
    drive(0, 4'b1111, 1, 0, 0);
    checks++; if (grant_idx_o !== 2'd3) begin errors++; $display("FAIL slow_first: got %0d expected 3", grant_idx_o); end
    tick();
    for (int w = 1; w <= 4; w++) begin
      drive(0, 4'b1111, 0, (w == 4), 0);
      checks++; if (grant_idx_o !== 2'd3 || grant_vld_o !== 1'b1) begin errors++; $display("FAIL slow_lock w=%0d: got idx %0d vld %b expected 3/1", w, grant_idx_o, grant_vld_o); end
      checks++; if (hold_flag_o !== 1'b1) begin errors++; $display("FAIL slow_hold w=%0d: got %b expected 1", w, hold_flag_o); end
      tick();
    end
    drive(0, 4'b1111, 0, 0, 0);
    checks++; if (grant_idx_o !== 2'd0) begin errors++; $display("FAIL slow_next: got %0d expected 0", grant_idx_o); end
    checks++; if (hold_flag_o !== 1'b0) begin errors++; $display("FAIL slow_release_hold: got %b expected 0", hold_flag_o); end
    tick();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    drive(1, 4'b0000, 0, 0, 0); tick();
    for (int c = 0; c < 2; c++) begin drive(0, 4'b1111, 0, 0, 0); tick(); end
    drive(0, 4'b1111, 1, 0, 0); tick();
    for (int w = 1; w <= TMO; w++) begin
      drive(0, 4'b1111, 0, 0, (w == TMO));
      checks++; if (grant_idx_o !== 2'd2) begin errors++; $display("FAIL tmo_lock w=%0d: got %0d expected 2", w, grant_idx_o); end
      checks++; if (timeout_o !== (w == TMO)) begin errors++; $display("FAIL tmo_pulse w=%0d: got %b expected %b", w, timeout_o, w == TMO); end
      if (timeout_o === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL tmo_count: got %0d expected 1", pulses); end
    drive(0, 4'b1111, 0, 0, 0);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b expected 1", err_o); end
    checks++; if (grant_idx_o !== 2'd3) begin errors++; $display("FAIL tmo_next: got %0d expected 3", grant_idx_o); end
    tick();
    drive(0, 4'b0000, 0, 0, 1);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b expected 1", err_o); end
    tick();
    drive(0, 4'b0000, 0, 0, 0);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_err_clr: got %b expected 0", err_o); end
    tick();
  endtask

  task automatic test_abandon();
    drive(1, 4'b0000, 0, 0, 0); tick();
    for (int c = 0; c < 2; c++) begin drive(0, 4'b1111, 0, 0, 0); tick(); end
    drive(0, 4'b1111, 1, 0, 0); tick();
    for (int w = 1; w <= 2; w++) begin drive(0, 4'b1111, 0, 0, 0); tick(); end
    drive(0, 4'b1011, 0, 0, 0);
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL abandon_grant: got %b expected 0000", grant_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL abandon_tmo: got %b expected 0", timeout_o); end
    tick();
    drive(0, 4'b1011, 0, 0, 0);
    checks++; if (grant_idx_o !== 2'd3 || grant_vld_o !== 1'b1) begin errors++; $display("FAIL abandon_next: got %0d/%b expected 3/1", grant_idx_o, grant_vld_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL abandon_err: got %b expected 0", err_o); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(1, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b0001, 1, 0, 0); tick();
    for (int w = 0; w < 5; w++) begin drive(0, 4'b0001, 0, 0, 0); tick(); end
    drive(1, 4'b1111, 0, 0, 0);
    checks++; if (grant_o !== 4'b0000 || timeout_o !== 1'b0) begin errors++; $display("FAIL rstwait_during: got grant %b tmo %b expected 0000/0", grant_o, timeout_o); end
    tick();
    drive(0, 4'b1111, 0, 0, 0);
    checks++; if (grant_idx_o !== 2'd0 || hold_flag_o !== 1'b0) begin errors++; $display("FAIL rstwait_after: got idx %0d hold %b expected 0/0", grant_idx_o, hold_flag_o); end
    checks++; if (timeout_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rstwait_flags: got tmo %b err %b expected 0/0", timeout_o, err_o); end
    tick();
  endtask

  task automatic test_random();
    drive(1, 4'b0000, 0, 0, 0); tick();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] exp_g;
      drive(($urandom_range(99) == 0), 4'($urandom_range(15)), ($urandom_range(9) < 3),
            ($urandom_range(7) < 2), ($urandom_range(19) == 0));
      exp_g = e_vld ? (4'b0001 << e_idx) : 4'b0000;
      checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rnd_grant n=%0d: got %b expected %b", n, grant_o, exp_g); end
      checks++; if (grant_idx_o !== 2'(e_idx)) begin errors++; $display("FAIL rnd_idx n=%0d: got %0d expected %0d", n, grant_idx_o, e_idx); end
      checks++; if (grant_vld_o !== e_vld) begin errors++; $display("FAIL rnd_vld n=%0d: got %b expected %b", n, grant_vld_o, e_vld); end
      checks++; if (hold_flag_o !== e_hold) begin errors++; $display("FAIL rnd_hold n=%0d: got %b expected %b", n, hold_flag_o, e_hold); end
      checks++; if (timeout_o !== e_tmo) begin errors++; $display("FAIL rnd_tmo n=%0d: got %b expected %b", n, timeout_o, e_tmo); end
      checks++; if (err_o !== m_err) begin errors++; $display("FAIL rnd_err n=%0d: got %b expected %b", n, err_o, m_err); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; req_i = '0; slow_i = 1'b0; ack_i = 1'b0; err_clr_i = 1'b0;
    test_reset();
    test_rotation();
    test_sparse();
    test_slow_ack();
    test_timeout();
    test_abandon();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
